tri_bus_arbiter: RTL
====================

TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each channel's data and of the shared bus.
REQ-002 Parameter NCH, default 4, legal 2..16: number of requesting channels.
REQ-003 Parameter MAX_TENURE, default 4, legal >=1: maximum grant cycles while another channel is waiting.
REQ-004 Parameter TURN_CYC, default 1, legal >=1: bus-float (turnaround) cycles between owners.
REQ-005 clock  input  1  rising-edge clock; all state updates on this edge only.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  NCH  per-channel bus request, level-held while the channel wants the bus.
REQ-008 data_in  input  NCH*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
REQ-009 bus  output (tri)  WIDTH  shared bus; driven only by the owner, z otherwise.
REQ-010 gnt  output  NCH  registered one-hot grant; all zero when no owner.
REQ-011 owner  output  clog2(NCH)  index of the granted channel; 0 when gnt is zero.
REQ-012 busy  output  1  high in GRANT and TURN states.

Function
REQ-013 The FSM SHALL have three states: IDLE, GRANT and TURN.
REQ-014 IDLE: if any req bit is sampled high, the FSM SHALL go to GRANT with gnt set to the round-robin winner on the next cycle (1-cycle request-to-grant latency); otherwise it stays in IDLE.
REQ-015 Round-robin search SHALL start at last_owner+1 and wrap modulo NCH; last_owner SHALL update on every new grant.
REQ-016 bus SHALL equal the owner's data_in slice combinationally while gnt is nonzero, and SHALL be all-z whenever gnt is zero; at most one channel SHALL drive the bus at any time.
REQ-017 A tenure counter SHALL clear on grant and increment each GRANT cycle, saturating at MAX_TENURE-1.
REQ-018 GRANT to TURN, with gnt cleared on the next edge, SHALL occur when:
- req[owner] is sampled low; or
- the tenure counter equals MAX_TENURE-1 and any other req bit is high.
REQ-019 If the tenure limit is reached with no other request pending, the owner SHALL keep the bus indefinitely.
REQ-020 TURN SHALL last exactly TURN_CYC cycles with gnt zero and the bus z; on its final cycle the FSM SHALL arbitrate as in IDLE and go to GRANT or IDLE.
REQ-021 A preempted owner still holding req SHALL take part in the next arbitration at its round-robin position, which is lowest priority because it was the last owner.
REQ-022 req changes during TURN SHALL be ignored until the final TURN cycle's arbitration.
REQ-023 When several req bits rise in the same cycle, exactly one grant SHALL be issued, chosen by the round-robin order.

Reset
REQ-024 While reset is high at a clock edge:
- the FSM SHALL go to IDLE;
- gnt SHALL be 0, owner 0, busy 0;
- the tenure counter and the TURN counter SHALL be 0;
- last_owner SHALL be NCH-1, so channel 0 wins the first arbitration.
REQ-025 A reset during GRANT SHALL float the bus to z in the cycle after the reset edge, with no turnaround required.

Structure
REQ-026 The state encoding (IDLE=2'd0, GRANT=2'd1, TURN=2'd2) and the parameter defaults SHALL live in a shared package or header, tri_bus_defs.
REQ-027 The combinational round-robin picker SHALL be a separate sub-module, rr_pick, with inputs req and last_owner and outputs valid and winner index.
REQ-028 The tristate bus SHALL be built from per-channel, per-bit conditional drivers (bufif1-style) enabled by gnt[k].

Verification (NCH=4, WIDTH=8, MAX_TENURE=4, TURN_CYC=1)
REQ-029 Reset test: hold reset 2 cycles with all req=1 -> gnt=0 and bus=zz during reset; first grant is gnt=0001 one cycle after reset falls.
REQ-030 Single channel: req=0100, data_in[2]=8'hA5; hold 3 cycles then drop -> gnt=0100 for 3 cycles and bus=A5; 1 TURN cycle with bus=zz; then IDLE.
REQ-031 Round-robin under load: req=1111 held throughout -> owner sequence 0,1,2,3,0; each tenure is 4 cycles followed by 1 z cycle.
REQ-032 Tenure without contention: req=0010 alone for 10 cycles -> gnt=0010 for all 10 cycles; no TURN until req drops.
REQ-033 Reset mid-GRANT: reset asserted in the 2nd grant cycle of channel 3 -> bus=zz and gnt=0 on the next cycle; after release, channel 0 has priority.
REQ-034 Contention checker active in every test: never more than one gnt bit set, and bus never x while gnt is nonzero with known data_in.

Source files
------------

// File: rtl/tri_bus_arbiter_pkg.sv
// Shared definitions for the tristate bus arbiter: FSM encoding and parameter defaults.
package tri_bus_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_NCH        = 4;
  localparam int DEF_MAX_TENURE = 4;
  localparam int DEF_TURN_CYC   = 1;

  // Counter width that stays legal when the count range collapses to a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping.
module rr_pick #(
  parameter int NCH = 4,
  parameter int OW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [OW-1:0]  last_owner,
  output logic           valid,
  output logic [OW-1:0]  winner
);

  logic [OW-1:0] idx;

  // Scan from the farthest position down to last_owner+1 so the nearest requester wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = OW'((int'(last_owner) + i) % NCH);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbitration for a shared tristate bus with tenure limit and turnaround.
module tri_bus_arbiter
  import tri_bus_defs::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NCH        = DEF_NCH,
  parameter int MAX_TENURE = DEF_MAX_TENURE,
  parameter int TURN_CYC   = DEF_TURN_CYC
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*WIDTH-1:0]   data_in,
  output tri   [WIDTH-1:0]       bus,
  output logic [NCH-1:0]         gnt,
  output logic [$clog2(NCH)-1:0] owner,
  output logic                   busy
);

  localparam int OW     = $clog2(NCH);
  localparam int TEN_W  = cnt_w(MAX_TENURE);
  localparam int TURN_W = cnt_w(TURN_CYC);
  localparam logic [TEN_W-1:0]  TEN_MAX  = TEN_W'(MAX_TENURE - 1);
  localparam logic [TURN_W-1:0] TURN_MAX = TURN_W'(TURN_CYC - 1);

  arb_state_t        state, state_n;
  logic [NCH-1:0]    gnt_n;
  logic [OW-1:0]     owner_n;
  logic [OW-1:0]     last_owner, last_n;
  logic [TEN_W-1:0]  ten, ten_n;
  logic [TURN_W-1:0] turn_cnt, turn_n;
  logic              arb;
  logic              pick_valid;
  logic [OW-1:0]     pick_winner;

  rr_pick #(.NCH(NCH), .OW(OW)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // State, grant and counter registers; reset hands first priority to channel 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      owner      <= '0;
      last_owner <= OW'(NCH - 1);
      ten        <= '0;
      turn_cnt   <= '0;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      owner      <= owner_n;
      last_owner <= last_n;
      ten        <= ten_n;
      turn_cnt   <= turn_n;
    end
  end

  // Next-state: hold, release on dropped request or expired tenure under contention, re-arbitrate.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    last_n  = last_owner;
    ten_n   = ten;
    turn_n  = turn_cnt;
    arb     = 1'b0;
    unique case (state)
      ST_IDLE: arb = 1'b1;
      ST_GRANT: begin
        if (!req[owner] || ((ten == TEN_MAX) && (|(req & ~gnt)))) begin
          state_n = ST_TURN;
          gnt_n   = '0;
          owner_n = '0;
          turn_n  = '0;
        end else if (ten != TEN_MAX) begin
          ten_n = ten + 1'b1;
        end
      end
      ST_TURN: begin
        // Requests are only looked at on the last turnaround cycle.
        if (turn_cnt == TURN_MAX) arb = 1'b1;
        else turn_n = turn_cnt + 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    if (arb) begin
      if (pick_valid) begin
        state_n              = ST_GRANT;
        gnt_n                = '0;
        gnt_n[pick_winner]   = 1'b1;
        owner_n              = pick_winner;
        last_n               = pick_winner;
        ten_n                = '0;
      end else begin
        state_n = ST_IDLE;
      end
    end
  end

  assign busy = (state != ST_IDLE);

  // Per-channel, per-bit conditional drivers; the one-hot grant guarantees a single driver.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      assign bus[b] = gnt[k] ? data_in[k*WIDTH + b] : 1'bz;
    end
  end

endmodule
